// File: rtl/ntt_pkg.sv
// Shared types and parameter helpers for the NTT address sequencer.
// Defines the FSM state type and the derivation of counter/stage widths.
package ntt_pkg;

    localparam int unsigned DEF_LOG_N          = 12;
    localparam int unsigned DEF_LOG_CORE_COUNT = 4;
    localparam int unsigned DEF_PIPE_STAGES    = 10;
    localparam int unsigned DEF_STAGE_GAP      = 0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap,
        StDrain
    } ntt_state_e;

    // Per-core address count exponent: butterflies per stage split over the cores.
    function automatic int unsigned calc_j(input int unsigned log_n,
                                           input int unsigned log_core_count);
        return log_n - 1 - log_core_count;
    endfunction

    function automatic int unsigned calc_aw(input int unsigned log_n,
                                            input int unsigned log_core_count);
        return calc_j(log_n, log_core_count);
    endfunction

    function automatic int unsigned calc_sw(input int unsigned log_n);
        return $clog2(log_n);
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-latency shift register with synchronous clear.
// Carries the read-side control word forward to the write side of the cores.
module ntt_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_sequencer.sv
// Address and stage sequencer for a multi-core in-place NTT.
// Issues per-stage read addresses and a delayed write-side copy for the butterfly cores.
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int unsigned  LOG_N          = DEF_LOG_N,
    parameter int unsigned  LOG_CORE_COUNT = DEF_LOG_CORE_COUNT,
    parameter int unsigned  PIPE_STAGES    = DEF_PIPE_STAGES,
    parameter int unsigned  STAGE_GAP      = DEF_STAGE_GAP,
    localparam int unsigned AW             = calc_aw(LOG_N, LOG_CORE_COUNT),
    localparam int unsigned SW             = calc_sw(LOG_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          inverse,
    input  logic          pause,
    output logic          busy,
    output logic          done,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr_even,
    output logic [AW-1:0] rd_addr_odd,
    output logic          rd_bank,
    output logic [SW-1:0] log_m,
    output logic [SW-1:0] log_t,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr_even,
    output logic [AW-1:0] wr_addr_odd,
    output logic          wr_bank,
    output logic [SW-1:0] wr_log_m
);

    localparam int unsigned J        = calc_j(LOG_N, LOG_CORE_COUNT);
    localparam int unsigned WAIT_MAX = (STAGE_GAP > PIPE_STAGES) ? STAGE_GAP : PIPE_STAGES;
    localparam int unsigned WW       = $clog2(WAIT_MAX + 1);
    localparam int unsigned DW       = 2 + 2 * AW + SW;

    localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};
    localparam logic [SW-1:0] LAST_S  = SW'(LOG_N - 1);

    ntt_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] s_q, s_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          inv_q, inv_d;
    logic          bank_q, bank_d;
    logic          done_q, done_d;
    logic          last_stage;
    logic [DW-1:0] dl_in, dl_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            s_q     <= '0;
            wait_q  <= '0;
            inv_q   <= 1'b0;
            bank_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            wait_q  <= wait_d;
            inv_q   <= inv_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
        end
    end

    assign last_stage = inv_q ? (s_q == '0) : (s_q == LAST_S);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        wait_d  = wait_q;
        inv_d   = inv_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    inv_d   = inverse;
                    bank_d  = 1'b0;
                    s_d     = inverse ? LAST_S : '0;
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!pause) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == CNT_MAX) begin
                        cnt_d  = '0;
                        bank_d = ~bank_q;
                        wait_d = '0;
                        // s is held on the final stage so it never leaves its range.
                        if (last_stage) begin
                            state_d = StDrain;
                        end else begin
                            s_d = inv_q ? (s_q - SW'(1)) : (s_q + SW'(1));
                            if (STAGE_GAP > 0) begin
                                state_d = StGap;
                            end
                        end
                    end
                end
            end
            StGap: begin
                if (wait_q == WW'(STAGE_GAP - 1)) begin
                    state_d = StIssue;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            StDrain: begin
                // Last write leaves PIPE_STAGES cycles after the last read, plus one idle cycle.
                if (wait_q == WW'(PIPE_STAGES)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    bank_d  = 1'b0;
                    s_d     = '0;
                    inv_d   = 1'b0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q != StIdle);
        done         = done_q;
        rd_valid     = (state_q == StIssue) && !pause;
        rd_bank      = bank_q;
        rd_addr_even = '0;
        rd_addr_odd  = '0;
        log_m        = '0;
        log_t        = '0;
        if (busy) begin
            rd_addr_even = cnt_q;
            log_m        = s_q;
            log_t        = LAST_S - s_q;
            // Odd cores start half a block later to keep the two banks conflict-free.
            rd_addr_odd  = cnt_q;
            for (int b = 0; b < int'(J); b++) begin
                if (int'(log_t) == b + 1) begin
                    rd_addr_odd[b] = ~cnt_q[b];
                end
            end
        end
    end

    assign dl_in = {rd_valid, rd_addr_even, rd_addr_odd, busy & ~rd_bank, log_m};

    ntt_delay_line #(
        .WIDTH(DW),
        .DEPTH(PIPE_STAGES)
    ) u_delay (
        .clk (clk),
        .clr (rst),
        .din (dl_in),
        .dout(dl_out)
    );

    assign {wr_valid, wr_addr_even, wr_addr_odd, wr_bank, wr_log_m} = dl_out;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Bench for ntt_sequencer: two instances (no gap, 2-cycle gap) against a schedule-queue model.
// Directed scenarios pin the model with literal timings, then random stimulus runs.
module tb_ntt_sequencer;

    localparam int LOG_N = 4;
    localparam int J     = 2;
    localparam int AW    = 2;
    localparam int SW    = 2;
    localparam int PS    = 3;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] e;
        logic [AW-1:0] o;
        logic          b;
        logic [SW-1:0] lm;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic inverse = 1'b0;
    logic pause = 1'b0;

    logic          busy_o [2];
    logic          done_o [2];
    logic          rd_v   [2];
    logic [AW-1:0] rd_e   [2];
    logic [AW-1:0] rd_o   [2];
    logic          rd_b   [2];
    logic [SW-1:0] lm_o   [2];
    logic [SW-1:0] lt_o   [2];
    logic          wr_v   [2];
    logic [AW-1:0] wr_e   [2];
    logic [AW-1:0] wr_o   [2];
    logic          wr_b   [2];
    logic [SW-1:0] wr_lm  [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int gaps [2] = '{0, 2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_sequencer #(
        .LOG_N(4), .LOG_CORE_COUNT(1), .PIPE_STAGES(3), .STAGE_GAP(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse), .pause(pause),
        .busy(busy_o[0]), .done(done_o[0]), .rd_valid(rd_v[0]), .rd_addr_even(rd_e[0]),
        .rd_addr_odd(rd_o[0]), .rd_bank(rd_b[0]), .log_m(lm_o[0]), .log_t(lt_o[0]),
        .wr_valid(wr_v[0]), .wr_addr_even(wr_e[0]), .wr_addr_odd(wr_o[0]), .wr_bank(wr_b[0]),
        .wr_log_m(wr_lm[0])
    );

    ntt_sequencer #(
        .LOG_N(4), .LOG_CORE_COUNT(1), .PIPE_STAGES(3), .STAGE_GAP(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse), .pause(pause),
        .busy(busy_o[1]), .done(done_o[1]), .rd_valid(rd_v[1]), .rd_addr_even(rd_e[1]),
        .rd_addr_odd(rd_o[1]), .rd_bank(rd_b[1]), .log_m(lm_o[1]), .log_t(lt_o[1]),
        .wr_valid(wr_v[1]), .wr_addr_even(wr_e[1]), .wr_addr_odd(wr_o[1]), .wr_bank(wr_b[1]),
        .wr_log_m(wr_lm[1])
    );

    task automatic chk(input string nm, input int d, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm, d, cyc, act, exp);
        end
    endtask

    function automatic int stage_s(input bit inv, input int k);
        return inv ? (LOG_N - 1 - k) : k;
    endfunction

    function automatic int odd_of(input int c, input int lt);
        if (lt >= 1 && lt <= J) return c ^ (1 << (lt - 1));
        return c;
    endfunction

    // Model: a transform is a queue of slots (issue k*16+cnt, or gap 1000+next_k).
    bit   m_active [2];
    bit   m_inv    [2];
    bit   m_done   [2];
    int   m_sched  [2][32];
    int   m_head   [2];
    int   m_len    [2];
    int   m_drain  [2];
    rec_t m_hist   [2][PS];

    // Directed-scenario records (relative to t0).
    bit rec_on = 1'b0;
    int t0 = 0;
    int first_rd [2], last_rd [2], n_rd [2], first_wr [2], last_wr [2], first_done [2];
    int odd1 [$];
    int lmseq [$];

    int h, k, c, exp_v, exp_e, exp_o, exp_b, exp_lm, rel;
    bit lm_known, dn;
    rec_t r, hr;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 0; m_inv[d] = 0; m_done[d] = 0; m_head[d] = 0; m_len[d] = 0;
            m_drain[d] = 0;
            for (int i = 0; i < PS; i++) m_hist[d][i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_v = 0; exp_e = 0; exp_o = 0; exp_b = 0; exp_lm = 0; lm_known = 0; h = 0;
            if (!m_active[d]) begin
                lm_known = 1;
            end else if (m_len[d] > 0) begin
                h = m_sched[d][m_head[d]];
                lm_known = 1;
                if (h >= 1000) begin
                    exp_lm = stage_s(m_inv[d], h - 1000);
                end else begin
                    k = h / 16; c = h % 16;
                    exp_lm = stage_s(m_inv[d], k);
                    if (!pause) begin
                        exp_v = 1; exp_e = c; exp_o = odd_of(c, LOG_N - 1 - exp_lm);
                        exp_b = k % 2;
                    end
                end
            end

            chk("busy", d, busy_o[d], m_active[d]);
            chk("done", d, done_o[d], m_done[d]);
            chk("rd_valid", d, rd_v[d], exp_v);
            if (exp_v != 0) begin
                chk("rd_addr_even", d, rd_e[d], exp_e);
                chk("rd_addr_odd", d, rd_o[d], exp_o);
                chk("rd_bank", d, rd_b[d], exp_b);
            end
            if (!m_active[d]) begin
                chk("idle_addr_even", d, rd_e[d], 0);
                chk("idle_addr_odd", d, rd_o[d], 0);
            end
            if (lm_known) begin
                chk("log_m", d, lm_o[d], exp_lm);
                chk("log_t", d, lt_o[d], m_active[d] ? (LOG_N - 1 - exp_lm) : 0);
            end
            hr = m_hist[d][PS-1];
            chk("wr_valid", d, wr_v[d], hr.v);
            if (hr.v) begin
                chk("wr_addr_even", d, wr_e[d], hr.e);
                chk("wr_addr_odd", d, wr_o[d], hr.o);
                chk("wr_bank", d, wr_b[d], hr.b);
                chk("wr_log_m", d, wr_lm[d], hr.lm);
            end

            if (rec_on) begin
                rel = cyc - t0;
                if (rd_v[d]) begin
                    if (first_rd[d] < 0) first_rd[d] = rel;
                    last_rd[d] = rel;
                    n_rd[d]++;
                    if (d == 0 && lm_o[0] == 1) odd1.push_back(int'(rd_o[0]));
                    if (d == 0 && rd_e[0] == 0) lmseq.push_back(int'(lm_o[0]));
                end
                if (wr_v[d]) begin
                    if (first_wr[d] < 0) first_wr[d] = rel;
                    last_wr[d] = rel;
                end
                if (done_o[d] && first_done[d] < 0) first_done[d] = rel;
            end

            if (rst) begin
                m_active[d] = 0; m_len[d] = 0; m_done[d] = 0;
                for (int i = 0; i < PS; i++) m_hist[d][i] = '0;
            end else begin
                for (int i = PS - 1; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
                r = '0;
                if (exp_v != 0) begin
                    r.v = 1'b1; r.e = exp_e[AW-1:0]; r.o = exp_o[AW-1:0];
                    r.b = ~exp_b[0]; r.lm = exp_lm[SW-1:0];
                end
                m_hist[d][0] = r;
                dn = 0;
                if (!m_active[d]) begin
                    if (start) begin
                        m_inv[d] = inverse; m_head[d] = 0; m_len[d] = 0; m_active[d] = 1;
                        for (int s = 0; s < LOG_N; s++) begin
                            for (int a = 0; a < (1 << J); a++) begin
                                m_sched[d][m_len[d]] = s * 16 + a; m_len[d]++;
                            end
                            if (s < LOG_N - 1) begin
                                for (int g = 0; g < gaps[d]; g++) begin
                                    m_sched[d][m_len[d]] = 1000 + s + 1; m_len[d]++;
                                end
                            end
                        end
                    end
                end else if (m_len[d] > 0) begin
                    if (h >= 1000 || !pause) begin
                        m_head[d]++; m_len[d]--;
                        if (m_len[d] == 0) m_drain[d] = PS + 1;
                    end
                end else begin
                    m_drain[d]--;
                    if (m_drain[d] == 0) begin
                        m_active[d] = 0; dn = 1;
                    end
                end
                m_done[d] = dn;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_rec();
        for (int d = 0; d < 2; d++) begin
            first_rd[d] = -1; last_rd[d] = -1; n_rd[d] = 0;
            first_wr[d] = -1; last_wr[d] = -1; first_done[d] = -1;
        end
        odd1.delete();
        lmseq.delete();
        t0 = cyc;
        rec_on = 1'b1;
    endtask

    int exp_odd1 [4] = '{2, 3, 0, 1};
    int exp_lmi  [4] = '{3, 2, 1, 0};

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Forward run with both gap settings.
        clr_rec(); start = 1'b1; inverse = 1'b0; tick(); start = 1'b0;
        repeat (35) tick();
        rec_on = 1'b0;
        chk("fwd_first_rd", 0, first_rd[0], 1);
        chk("fwd_last_rd", 0, last_rd[0], 16);
        chk("fwd_n_rd", 0, n_rd[0], 16);
        chk("fwd_first_wr", 0, first_wr[0], 4);
        chk("fwd_last_wr", 0, last_wr[0], 19);
        chk("fwd_done", 0, first_done[0], 21);
        chk("gap_last_rd", 1, last_rd[1], 22);
        chk("gap_n_rd", 1, n_rd[1], 16);
        chk("gap_done", 1, first_done[1], 27);
        chk("fwd_odd1_len", 0, odd1.size(), 4);
        for (int i = 0; i < odd1.size() && i < 4; i++) chk("fwd_odd1", 0, odd1[i], exp_odd1[i]);

        // Inverse run.
        clr_rec(); start = 1'b1; inverse = 1'b1; tick(); start = 1'b0; inverse = 1'b0;
        repeat (35) tick();
        rec_on = 1'b0;
        chk("inv_stage_len", 0, lmseq.size(), 4);
        for (int i = 0; i < lmseq.size() && i < 4; i++) chk("inv_log_m", 0, lmseq[i], exp_lmi[i]);
        chk("inv_done", 0, first_done[0], 21);

        // Pause in cycles 5..7 plus a start while busy.
        clr_rec(); start = 1'b1; tick();
        for (int i = 1; i < 40; i++) begin
            pause = (i >= 5 && i <= 7);
            start = (i == 5);
            tick();
        end
        pause = 1'b0; start = 1'b0;
        rec_on = 1'b0;
        chk("pause_n_rd", 0, n_rd[0], 16);
        chk("pause_last_rd", 0, last_rd[0], 19);
        chk("pause_last_wr", 0, last_wr[0], 22);
        chk("pause_done", 0, first_done[0], 24);

        // Reset mid-transform, restart at cycle 12.
        clr_rec(); start = 1'b1; tick();
        for (int i = 1; i < 40; i++) begin
            rst = (i == 9);
            start = (i == 12);
            if (i == 10) begin
                @(negedge clk);
                chk("rst_busy", 0, busy_o[0], 0);
                chk("rst_rd_valid", 0, rd_v[0], 0);
                chk("rst_wr_valid", 0, wr_v[0], 0);
                chk("rst_wr_addr_even", 0, wr_e[0], 0);
                chk("rst_wr_addr_odd", 0, wr_o[0], 0);
                chk("rst_wr_bank", 0, wr_b[0], 0);
                chk("rst_wr_log_m", 0, wr_lm[0], 0);
                chk("rst_rd_bank", 0, rd_b[0], 0);
                chk("rst_log_t", 0, lt_o[0], 0);
            end
            tick();
        end
        start = 1'b0; rst = 1'b0;
        rec_on = 1'b0;
        chk("rst_restart_done", 0, first_done[0], 33);

        // Start held through done.
        clr_rec(); start = 1'b1;
        repeat (50) tick();
        start = 1'b0;
        repeat (30) tick();
        rec_on = 1'b0;
        chk("held_done", 0, first_done[0], 21);

        // Random stimulus.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom % 200) == 0;
            start   = ($urandom % 8) == 0;
            inverse = $urandom % 2;
            pause   = ($urandom % 5) == 0;
            tick();
        end
        rst = 1'b0; start = 1'b0; pause = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ntt_sequencer.md
NTT_SEQUENCER -- requirements
Module: ntt_sequencer

Interface
REQ-001 The module SHALL take these parameters:
- LOG_N, default 12: log2 of the transform length.
- LOG_CORE_COUNT, default 4: log2 of the butterfly core count.
- PIPE_STAGES, default 10: read-to-write latency of the cores, ≥1.
- STAGE_GAP, default 0: idle cycles inserted between stages.
REQ-002 Derived constants SHALL be J = LOG_N-1-LOG_CORE_COUNT (≥1), AW = J (address width) and SW = $clog2(LOG_N) (stage width).
REQ-003 There SHALL be one clock; reset is synchronous and active-high. Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin transform; sampled only when idle
- inverse  in  1  0 = forward (DIT order), 1 = inverse (reversed stage order); captured with start
- pause  in  1  suspends address issue
- busy  out  1  transform in progress
- done  out  1  single-cycle completion pulse
- rd_valid  out  1  read addresses valid this cycle
- rd_addr_even  out  AW  read address for even cores
- rd_addr_odd  out  AW  read address for odd cores
- rd_bank  out  1  ping-pong read bank
- log_m  out  SW  current stage index s
- log_t  out  SW  LOG_N-1-s
- wr_valid  out  1  rd_valid delayed PIPE_STAGES cycles
- wr_addr_even  out  AW  delayed rd_addr_even
- wr_addr_odd  out  AW  delayed rd_addr_odd
- wr_bank  out  1  delayed inverse of rd_bank
- wr_log_m  out  SW  delayed log_m

Function
REQ-004 States SHALL be IDLE, ISSUE, GAP and DRAIN.
REQ-005 In IDLE with start=1, the block SHALL capture inverse, set busy=1, set rd_bank=0, set s=0 (forward) or LOG_N-1 (inverse), clear cnt, and enter ISSUE.
REQ-006 start SHALL be ignored whenever busy=1.
REQ-007 In ISSUE with pause=0, each cycle SHALL assert rd_valid=1 with rd_addr_even=cnt and then increment cnt. cnt runs 0..2^J-1.
REQ-008 rd_addr_odd SHALL equal cnt with bit (log_t-1) inverted when 1≤log_t≤J, and SHALL equal cnt otherwise. This half-block start avoids bank conflicts.
REQ-009 In ISSUE with pause=1, rd_valid SHALL be 0 and cnt, s and the state SHALL hold. The write pipeline keeps shifting.
REQ-010 At cnt=2^J-1 (issued), cnt SHALL wrap to 0, rd_bank SHALL toggle, and s SHALL step +1 (forward) or -1 (inverse).
REQ-011 After the issue cycle at cnt=2^J-1, the next state SHALL be GAP if STAGE_GAP>0 and further stages remain, otherwise ISSUE.
REQ-012 After the final stage (s=LOG_N-1 forward, s=0 inverse), the next state SHALL be DRAIN.
REQ-013 GAP SHALL last exactly STAGE_GAP cycles with rd_valid=0, and SHALL ignore pause.
REQ-014 The wr_* outputs SHALL be exact PIPE_STAGES-cycle delays of rd_valid, the addresses, ~rd_bank and log_m.
REQ-015 DRAIN SHALL persist until wr_valid has been low for one cycle after its final high cycle. done SHALL then pulse high for 1 cycle, busy SHALL drop in the same cycle, and the state SHALL return to IDLE.
REQ-016 Total issue cycles with no pause SHALL be LOG_N·2^J + (LOG_N-1)·STAGE_GAP.
REQ-017 log_t SHALL always equal LOG_N-1-log_m. No arithmetic SHALL overflow its declared width.
REQ-018 While IDLE, rd_valid=0 and the rd_addr_even, rd_addr_odd, log_m and log_t outputs SHALL be 0.

Reset
REQ-019 rst=1 SHALL force IDLE and clear the delay line, regardless of state or pause, including mid-transform.
REQ-020 Under rst=1, all outputs SHALL be 0 on the next edge: busy=0, done=0, rd_valid=0, wr_valid=0, all addresses, banks and stage outputs=0.
REQ-021 start asserted during reset SHALL be ignored.

Structure
REQ-022 State enum, J/AW/SW derivation functions and default parameter constants SHALL reside in the shared package ntt_pkg.
REQ-023 The delay path SHALL be one sub-module, ntt_delay_line, parameterised by width and depth with synchronous clear. It SHALL be instantiated once on the concatenated {valid, addrs, bank, log_m}.
REQ-024 The block SHALL contain no datapath arithmetic beyond counters.

Verification
All scenarios use LOG_N=4, LOG_CORE_COUNT=1 (J=2), PIPE_STAGES=3, STAGE_GAP=0 unless stated.
REQ-025 Forward run: start at cycle 0.
- rd_valid high cycles 1..16, rd_addr_even 0,1,2,3 each stage.
- rd_addr_odd: stage0 0,1,2,3; stage1 2,3,0,1; stage2 1,0,3,2; stage3 0,1,2,3.
- wr_valid high cycles 4..19; done at cycle 21; busy low at cycle 21.
REQ-026 Inverse run: log_m sequence 3,2,1,0; rd_bank toggles at each stage boundary; same odd patterns per log_t as in REQ-025.
REQ-027 STAGE_GAP=2: three 2-cycle rd_valid=0 gaps; last rd_valid at cycle 22; done at cycle 27.
REQ-028 pause high for cycles 5..7: issue freezes at stage1 cnt=0 and resumes with cnt=0 at cycle 8; no address skipped or duplicated; wr_valid shows the same 3-cycle hole.
REQ-029 rst at cycle 9 of a run: all outputs 0 at cycle 10; no wr_valid afterwards; no done; a new start at cycle 12 gives a clean run.
REQ-030 start re-asserted at cycle 5 while busy is ignored; a start held through done begins a new run on the cycle after done.
